wb_shadow_regfile: RTL and testbench

- Sits directly downstream of the write-back delay shift register in the system diagnosis path.
- Consumes delayed write-back events (enable, register index, data) and keeps a shadow copy of the CPU register file, lagging the core by the snapshot delay.
- On a snapshot request, freezes a copy of the shadow file and streams the selected registers out over a valid/ready interface to the diagnosis packetizer.

---
 rtl/wb_shadow_regfile_pkg.sv | 19 +
 rtl/wb_shadow_regfile_enc.sv | 30 +++
 rtl/wb_shadow_regfile.sv | 127 ++++++++++++
 tb/tb_wb_shadow_regfile.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_shadow_regfile_pkg.sv
// ----------------------------------------------------------------------------
// wb_shadow_regfile_pkg
// Shared widths and types for the write-back shadow register file used in the
// system diagnosis path.
//   DIAG_WB_REG_WIDTH  : register index width of the delayed write-back bus
//   DIAG_WB_DATA_WIDTH : register data width of the delayed write-back bus
//   dump_state_e       : dump controller states
// ----------------------------------------------------------------------------
package wb_shadow_regfile_pkg;

  localparam int DIAG_WB_REG_WIDTH  = 5;
  localparam int DIAG_WB_DATA_WIDTH = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DUMP = 1'b1
  } dump_state_e;

endpackage : wb_shadow_regfile_pkg

// File: rtl/wb_shadow_regfile_enc.sv
// ----------------------------------------------------------------------------
// diag_lowest_bit_enc
// Lowest-set-bit priority encoder with an "exactly one bit set" flag.
//   i_vec      : input vector (N bits)
//   o_idx      : index of the lowest set bit (0 when i_vec is all zero)
//   o_one_hot  : 1 when exactly one bit of i_vec is set
// ----------------------------------------------------------------------------
module diag_lowest_bit_enc #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_one_hot
);

  // NOTE: o_idx is given a default before the loop so every path assigns it
  // and no latch is inferred; scanning from the top down lets the lowest set
  // bit be the last (winning) blocking assignment.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = W'(i);
    end
  end

  // x & (x - 1) removes the lowest set bit; zero afterwards means one bit only.
  assign o_one_hot = (i_vec != '0) && ((i_vec & (i_vec - N'(1))) == '0);

endmodule : diag_lowest_bit_enc

// File: rtl/wb_shadow_regfile.sv
// ----------------------------------------------------------------------------
// wb_shadow_regfile
// Shadow copy of the CPU register file fed by delayed write-back events. A
// snapshot request freezes the shadow file and streams the masked registers
// out, lowest index first, over a valid/ready interface.
//   clk, rst            : clock, asynchronous active-low reset
//   wb_enable_i/reg/data: delayed write-back event
//   snapshot_req_i      : request pulse, reg_mask_i sampled with it
//   out_valid_o/ready_i : dump beat handshake
//   out_reg_o/data_o    : register index and value of the beat
//   out_last_o          : final beat of the dump
//   busy_o              : dump in progress
//   snapshot_dropped_o  : request arrived while a dump was in progress
// ----------------------------------------------------------------------------
module wb_shadow_regfile
  import wb_shadow_regfile_pkg::*;
#(
  parameter int REG_WIDTH          = DIAG_WB_REG_WIDTH,
  parameter int DATA_WIDTH         = DIAG_WB_DATA_WIDTH,
  parameter int NUM_REGS           = 1 << REG_WIDTH,
  parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_enable_i,
  input  logic [REG_WIDTH-1:0]  wb_reg_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  snapshot_req_i,
  input  logic [NUM_REGS-1:0]   reg_mask_i,
  output logic                  out_valid_o,
  output logic [REG_WIDTH-1:0]  out_reg_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  snapshot_dropped_o
);

  dump_state_e           r_state;
  dump_state_e           w_next_state;
  logic [DATA_WIDTH-1:0] r_shadow [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_snap   [NUM_REGS];
  logic [NUM_REGS-1:0]   r_pending;

  logic [REG_WIDTH-1:0]  w_idx;
  logic                  w_one_hot;
  logic                  w_dump;
  logic                  w_accept;
  logic                  w_beat;
  logic                  w_wb_ok;
  logic [NUM_REGS-1:0]   w_start_mask;

  assign w_dump   = (r_state == ST_DUMP);
  assign w_accept = (r_state == ST_IDLE) && snapshot_req_i && (reg_mask_i != '0);
  assign w_beat   = w_dump && out_ready_i;
  assign w_wb_ok  = wb_enable_i && !(ZERO_REG_HARDWIRED && (wb_reg_i == '0));

  // Reg 0 is dropped from a mask only when something else is requested; a
  // mask of just reg 0 still produces one beat carrying 0.
  assign w_start_mask = (ZERO_REG_HARDWIRED && (reg_mask_i != NUM_REGS'(1)))
                      ? (reg_mask_i & ~NUM_REGS'(1)) : reg_mask_i;

  diag_lowest_bit_enc #(
    .N (NUM_REGS),
    .W (REG_WIDTH)
  ) u_enc (
    .i_vec     (r_pending),
    .o_idx     (w_idx),
    .o_one_hot (w_one_hot)
  );

  // NOTE: the shadow and snapshot arrays are cleared by reset because a dump
  // after reset must report zeros; this keeps them in flops, not RAM macros.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= '0;
    end else if (w_wb_ok) begin
      r_shadow[wb_reg_i] <= wb_data_i;
    end
  end

  // Capture bypasses the same-cycle write-back so the snapshot includes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_snap[i] <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_snap[i] <= (w_wb_ok && (wb_reg_i == REG_WIDTH'(i))) ? wb_data_i : r_shadow[i];
      end
    end
  end

  // Accepted beat is always the lowest pending bit, so clearing the lowest
  // set bit retires it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
    end else if (w_accept) begin
      r_pending <= w_start_mask;
    end else if (w_beat) begin
      r_pending <= r_pending & (r_pending - NUM_REGS'(1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)            w_next_state = ST_DUMP;
      ST_DUMP: if (w_beat && w_one_hot) w_next_state = ST_IDLE;
      default:                          w_next_state = ST_IDLE;
    endcase
  end

  // Beat fields are gated so every output reads 0 outside a dump.
  assign out_valid_o        = w_dump;
  assign busy_o             = w_dump;
  assign out_reg_o          = w_dump ? w_idx : '0;
  assign out_data_o         = w_dump ? r_snap[w_idx] : '0;
  assign out_last_o         = w_dump && w_one_hot;
  assign snapshot_dropped_o = w_dump && snapshot_req_i;

endmodule : wb_shadow_regfile

// File: tb/tb_wb_shadow_regfile.sv
// ----------------------------------------------------------------------------
// tb_wb_shadow_regfile
// Self-checking bench for wb_shadow_regfile. A reference model keeps the
// shadow file as an array and an accepted dump as a queue of expected beats;
// DUT outputs are compared against it every cycle on the falling edge.
// ----------------------------------------------------------------------------
module tb_wb_shadow_regfile;

  localparam int RW = 5;
  localparam int DW = 32;
  localparam int NR = 32;

  typedef struct {
    logic [RW-1:0] idx;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wb_enable_i = 1'b0;
  logic [RW-1:0] wb_reg_i = '0;
  logic [DW-1:0] wb_data_i = '0;
  logic          snapshot_req_i = 1'b0;
  logic [NR-1:0] reg_mask_i = '0;
  logic          out_ready_i = 1'b0;
  logic          out_valid_o;
  logic [RW-1:0] out_reg_o;
  logic [DW-1:0] out_data_o;
  logic          out_last_o;
  logic          busy_o;
  logic          snapshot_dropped_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] m_shadow [NR];
  beat_t         m_q [$];

  wb_shadow_regfile dut (
    .clk                (clk),
    .rst                (rst),
    .wb_enable_i        (wb_enable_i),
    .wb_reg_i           (wb_reg_i),
    .wb_data_i          (wb_data_i),
    .snapshot_req_i     (snapshot_req_i),
    .reg_mask_i         (reg_mask_i),
    .out_valid_o        (out_valid_o),
    .out_reg_o          (out_reg_o),
    .out_data_o         (out_data_o),
    .out_last_o         (out_last_o),
    .out_ready_i        (out_ready_i),
    .busy_o             (busy_o),
    .snapshot_dropped_o (snapshot_dropped_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_shadow[i] = '0;
    m_q.delete();
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    logic          was_busy;
    logic [NR-1:0] m;
    beat_t         b;
    was_busy = (m_q.size() != 0);
    if (was_busy && out_ready_i) void'(m_q.pop_front());
    if (wb_enable_i && wb_reg_i != 0) m_shadow[wb_reg_i] = wb_data_i;
    if (!was_busy && snapshot_req_i && reg_mask_i != 0) begin
      m = reg_mask_i;
      if (m != 1) m[0] = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (m[i]) begin
          b.idx  = RW'(i);
          b.data = m_shadow[i];
          m_q.push_back(b);
        end
      end
    end
  endtask

  // Called just after a rising edge with inputs already applied.
  task automatic cycle();
    logic exp_valid;
    @(negedge clk);
    exp_valid = (m_q.size() != 0);
    check("valid", 64'(out_valid_o), 64'(exp_valid));
    check("busy", 64'(busy_o), 64'(exp_valid));
    check("dropped", 64'(snapshot_dropped_o), 64'(exp_valid && snapshot_req_i));
    if (exp_valid) begin
      check("reg", 64'(out_reg_o), 64'(m_q[0].idx));
      check("data", 64'(out_data_o), 64'(m_q[0].data));
      check("last", 64'(out_last_o), 64'(m_q.size() == 1));
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    wb_enable_i    = 1'b0;
    snapshot_req_i = 1'b0;
    reg_mask_i     = '0;
  endtask

  task automatic wb(input logic [RW-1:0] r, input logic [DW-1:0] d);
    wb_enable_i = 1'b1;
    wb_reg_i    = r;
    wb_data_i   = d;
    cycle();
    wb_enable_i = 1'b0;
  endtask

  task automatic request(input logic [NR-1:0] m);
    snapshot_req_i = 1'b1;
    reg_mask_i     = m;
    cycle();
    snapshot_req_i = 1'b0;
    reg_mask_i     = '0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (m_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_timeout", 64'(m_q.size() != 0), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(out_valid_o), 64'(0));
    check({tag, "_reg"}, 64'(out_reg_o), 64'(0));
    check({tag, "_data"}, 64'(out_data_o), 64'(0));
    check({tag, "_last"}, 64'(out_last_o), 64'(0));
    check({tag, "_busy"}, 64'(busy_o), 64'(0));
    check({tag, "_dropped"}, 64'(snapshot_dropped_o), 64'(0));
  endtask

  initial begin
    model_reset();
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready_i = 1'b1;
    cycle();

    // Basic dump: three beats back to back, busy drops after the last.
    wb(5'd1, 32'h1111_1111);
    wb(5'd5, 32'h5555_5555);
    wb(5'd31, 32'hDEAD_BEEF);
    request(32'h8000_0022);
    check("basic_first_reg", 64'(out_reg_o), 64'(1));
    check("basic_first_data", 64'(out_data_o), 64'(32'h1111_1111));
    drain(10);
    cycle();

    // Zero register and same-cycle bypass.
    wb(5'd0, 32'hFFFF_FFFF);
    wb_enable_i = 1'b1; wb_reg_i = 5'd3; wb_data_i = 32'hA5A5_A5A5;
    request(32'h9);
    wb_enable_i = 1'b0;
    check("bypass_reg", 64'(out_reg_o), 64'(3));
    check("bypass_data", 64'(out_data_o), 64'(32'hA5A5_A5A5));
    check("bypass_last", 64'(out_last_o), 64'(1));
    drain(4);
    request(32'h1);
    check("zero_reg_data", 64'(out_data_o), 64'(0));
    drain(4);

    // Backpressure with a write-back to a frozen register.
    wb(5'd1, 32'h1);
    wb(5'd2, 32'h2);
    out_ready_i = 1'b0;
    request(32'h6);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        wb(5'd1, 32'h99);
      end else begin
        cycle();
      end
    end
    out_ready_i = 1'b1;
    drain(6);
    request(32'h2);
    check("post_freeze_data", 64'(out_data_o), 64'(32'h99));
    drain(4);

    // Drops: one mid-dump, one in the final handshake cycle.
    request(32'h0000_00F0);
    begin
      int n = 0;
      while (m_q.size() != 0 && n < 20) begin
        snapshot_req_i = (n == 1) || (m_q.size() == 1);
        reg_mask_i     = 32'hFFFF_FFFF;
        cycle();
        n++;
      end
      idle_inputs();
    end
    // Empty mask in idle: no pulse, stays idle.
    snapshot_req_i = 1'b1; reg_mask_i = '0;
    cycle();
    idle_inputs();
    cycle();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      int sel;
      wb_enable_i    = ($urandom_range(0, 1) == 1);
      wb_reg_i       = RW'($urandom_range(0, NR - 1));
      wb_data_i      = $urandom;
      out_ready_i    = ($urandom_range(0, 3) != 0);
      snapshot_req_i = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 7);
      case (sel)
        0:       reg_mask_i = '0;
        1:       reg_mask_i = 32'h1;
        2:       reg_mask_i = 32'h9;
        3:       reg_mask_i = $urandom;
        default: reg_mask_i = $urandom & $urandom & $urandom;
      endcase
      cycle();
    end
    idle_inputs();
    out_ready_i = 1'b1;
    drain(40);

    // Reset mid-dump.
    request(32'hFFFF_FFFF);
    cycle(); cycle();
    out_ready_i = 1'b0;
    cycle();
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready_i = 1'b1;
    cycle();
    check("after_reset_busy", 64'(busy_o), 64'(0));
    request(32'h2);
    check("after_reset_reg", 64'(out_reg_o), 64'(1));
    check("after_reset_data", 64'(out_data_o), 64'(0));
    drain(4);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_wb_shadow_regfile
